fifo_mem_ctrl: RTL



---
 rtl/fifo_mem_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_mem_ctrl.sv
// Stream-side controller for a FIFO memory: valid/ready streams in,
// memory request strobes out, with a 2-entry read-return buffer.
module fifo_mem_ctrl #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             mem_wr_en_o,
  output logic [WIDTH-1:0] fifo_wr_data_o,
  output logic             mem_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rd_data_i,
  input  logic             mem_wr_err_i,
  input  logic             mem_rd_err_i,
  output logic [CNT_W-1:0] count_o,
  output logic             fault_o
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             prio_q, prio_d;
  logic             inflight_q;
  logic [1:0]       occ_q, occ_d;
  logic             wptr_q, rptr_q;
  logic [WIDTH-1:0] buf_q [2];

  logic             run, not_full;
  logic [1:0]       pend;
  logic             wr_elig, rd_elig;
  logic             rd_grant, wr_grant;
  logic             push, pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN: begin
        if (mem_wr_err_i || mem_rd_err_i)
          state_d = S_FAULT;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_INIT;
    endcase
  end

  // prio_q high means a contested cycle goes to the read side
  always_comb begin
    run      = (state_q == S_RUN);
    not_full = (count_q < DEPTH_C);
    pend     = occ_q + {1'b0, inflight_q};
    wr_elig  = run && not_full && in_valid_i;
    rd_elig  = run && (count_q != '0)
               && (pend < 2'd2);
    rd_grant = rd_elig && (!wr_elig || prio_q);
    wr_grant = wr_elig && !rd_grant;
    in_ready_o     = run && not_full && !rd_grant;
    mem_wr_en_o    = wr_grant;
    mem_rd_en_o    = rd_grant;
    fifo_wr_data_o = in_data_i;
    out_valid_o    = (occ_q != 2'd0);
    out_data_o     = buf_q[rptr_q];
    count_o        = count_q;
    fault_o        = (state_q == S_FAULT);
  end

  always_comb begin
    push    = inflight_q;
    pop     = out_valid_o && out_ready_i;
    count_d = count_q;
    if (wr_grant)      count_d = count_q + CNT_W'(1);
    else if (rd_grant) count_d = count_q - CNT_W'(1);
    prio_d = (wr_elig && rd_elig) ? !prio_q : prio_q;
    occ_d  = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      prio_q     <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      count_q    <= count_d;
      prio_q     <= prio_d;
      inflight_q <= rd_grant;
      occ_q      <= occ_d;
      if (push) begin
        buf_q[wptr_q] <= fifo_rd_data_i;
        wptr_q        <= !wptr_q;
      end
      if (pop) rptr_q <= !rptr_q;
    end
  end

endmodule
